// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, req/ack instruction-memory handshake, held
// instruction register with bubble insertion on redirect or when empty.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    localparam logic [31:0] BUBBLE = 32'hFC00_0000;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_ir_q, pc_ir_d;
    logic        boot_q, boot_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] target;

    assign target = redirect_target & ~32'd3;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        ir_d       = ir_q;
        pc_ir_d    = pc_ir_q;
        boot_d     = 1'b1;

        case (state_q)
            IDLE: begin
                // One full IDLE cycle after reset release before the first request.
                if (boot_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        ir_d    = imem_rdata;
                        pc_ir_d = pc_q;
                        pc_d    = pc_q + 32'd4;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    // Outstanding request must keep its address until acked.
                    req_addr_d = pc_q;
                    pc_d       = target;
                    state_d    = DROP;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (instr_ready) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d   = (state_d == REQ) || (state_d == DROP);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            ir_q       <= BUBBLE;
            pc_ir_q    <= RESET_PC;
            boot_q     <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ir_q       <= ir_d;
            pc_ir_q    <= pc_ir_d;
            boot_q     <= boot_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = (state_q == DROP) ? req_addr_q : pc_q;
    assign instr_valid = valid_q;
    assign instr       = valid_q ? ir_q : BUBBLE;
    assign opcode      = instr[31:26];
    assign pc_out      = pc_ir_q;
    assign pc_plus4    = pc_ir_q + 32'd4;

endmodule
